// File: rtl/multicycle_control_unit.sv
// Purpose : main sequencing FSM for the 16-bit multicycle datapath (fetch, decode, exec, mem, wb).
// Latency : ALU 4, LW 5, SW 4, branch 3, JMP 2 cycles with mem_ready held high; memory states add wait cycles.
// Backpress: FETCH/MEM hold their request until mem_ready; after TIMEOUT waiting cycles the access is aborted.
//
// Ports:
//   clk, reset              - rising-edge clock, synchronous active-high reset
//   opcode, mode            - instruction[15:12] / instruction[11] from the IR
//   zero                    - ALU zero flag (used in EXEC for branches)
//   mem_ready               - memory completes the current access this cycle
//   state                   - IDLE=0 FETCH=1 DECODE=2 EXEC=3 MEM=4 WB=5
//   ir_write, pc_write      - IR load / PC update enables
//   pc_src                  - 0=PC+1, 1=PC+sext(imm), 2=page jump
//   mem_read, mem_write     - memory request strobes
//   addr_src                - 0=PC, 1=ALU result
//   alu_src_b, alu_op       - ALU B select (0=rs1, 1=imm) and op (0=ADD, 1=SUB, 2=AND)
//   reg_write, wb_src       - register write enable and source (0=ALU, 1=memory)
//   instr_done              - one-cycle pulse when an instruction retires
//   illegal, mem_timeout    - one-cycle error pulses
//   instr_count             - wrapping count of retired instructions
module multicycle_control_unit #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [3:0]       opcode,
   input  logic             mode,
   input  logic             zero,
   input  logic             mem_ready,
   output logic [2:0]       state,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic             mem_read,
   output logic             mem_write,
   output logic             addr_src,
   output logic             alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_write,
   output logic             wb_src,
   output logic             instr_done,
   output logic             illegal,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WW = $clog2(TIMEOUT) + 1;

   localparam logic [3:0] OP_ADD = 4'd0;
   localparam logic [3:0] OP_SUB = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_LW  = 4'd3;
   localparam logic [3:0] OP_SW  = 4'd4;
   localparam logic [3:0] OP_BR  = 4'd5;
   localparam logic [3:0] OP_JMP = 4'd6;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5
   } state_t;

   state_t            state_q;
   state_t            state_d;
   logic [3:0]        opq;
   logic              modeq;
   logic [WW-1:0]     wait_cnt;
   logic [WW-1:0]     wait_d;
   logic [CNT_W-1:0]  cnt_q;
   logic              wait_limit;
   logic              in_mem_state;

   // Last permitted waiting cycle: a ready on this cycle still completes.
   assign wait_limit   = (wait_cnt == WW'(TIMEOUT - 1)) && !mem_ready;
   assign in_mem_state = (state_q == S_FETCH) || (state_q == S_MEM);

   assign state       = reset ? 3'd0 : state_q;
   assign instr_count = cnt_q;

   // State register plus the opcode/mode latch taken at the end of DECODE.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= S_IDLE;
         opq      <= 4'd0;
         modeq    <= 1'b0;
         wait_cnt <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         wait_cnt <= wait_d;
         if (state_q == S_DECODE) begin
            opq   <= opcode;
            modeq <= mode;
         end
         if (instr_done) begin
            cnt_q <= cnt_q + CNT_W'(1);
         end
      end
   end

   // Wait counter restarts whenever the state changes or an abort re-enters FETCH.
   always_comb begin
      wait_d = wait_cnt;
      if ((state_d != state_q) || mem_timeout) begin
         wait_d = '0;
      end else if (in_mem_state && !mem_ready) begin
         wait_d = wait_cnt + WW'(1);
      end
   end

   // Next-state and output decode.
   always_comb begin
      state_d     = state_q;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = 2'd0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      addr_src    = 1'b0;
      alu_src_b   = 1'b0;
      alu_op      = 2'd0;
      reg_write   = 1'b0;
      wb_src      = 1'b0;
      instr_done  = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;

      case (state_q)
         S_IDLE: begin
            state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_read = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_limit) begin
               // PC untouched, so the same instruction is fetched again.
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_DECODE: begin
            // The IR is stable here, so the raw opcode drives the decision.
            if (opcode == OP_JMP) begin
               pc_write   = 1'b1;
               pc_src     = 2'd2;
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (opcode > OP_JMP) begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            case (opq)
               OP_ADD, OP_SUB, OP_AND: begin
                  alu_src_b = modeq;
                  alu_op    = opq[1:0];
                  state_d   = S_WB;
               end
               OP_LW, OP_SW: begin
                  alu_src_b = 1'b1;
                  alu_op    = 2'd0;
                  state_d   = S_MEM;
               end
               OP_BR: begin
                  alu_op     = 2'd1;
                  instr_done = 1'b1;
                  // BEQ (mode 0) takes on zero, BNE (mode 1) on non-zero.
                  if (zero ^ modeq) begin
                     pc_write = 1'b1;
                     pc_src   = 2'd1;
                  end
                  state_d = S_FETCH;
               end
               default: begin
                  state_d = S_FETCH;
               end
            endcase
         end
         S_MEM: begin
            addr_src  = 1'b1;
            mem_read  = (opq == OP_LW);
            mem_write = (opq == OP_SW);
            if (mem_ready) begin
               if (opq == OP_LW) begin
                  state_d = S_WB;
               end else begin
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            end else if (wait_limit) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end
         end
         S_WB: begin
            reg_write  = 1'b1;
            wb_src     = (opq == OP_LW);
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Everything driven to the datapath is quiet while reset is held.
      if (reset) begin
         ir_write    = 1'b0;
         pc_write    = 1'b0;
         pc_src      = 2'd0;
         mem_read    = 1'b0;
         mem_write   = 1'b0;
         addr_src    = 1'b0;
         alu_src_b   = 1'b0;
         alu_op      = 2'd0;
         reg_write   = 1'b0;
         wb_src      = 1'b0;
         instr_done  = 1'b0;
         illegal     = 1'b0;
         mem_timeout = 1'b0;
      end
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Purpose : self-checking bench for multicycle_control_unit using a per-cycle expectation queue.
// Latency : one queue entry per clock; inputs driven 1 time unit after posedge, outputs sampled at negedge.
// Backpress: mem_ready waits and timeouts are scripted per entry.
module tb_multicycle_control_unit;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  opcode = 4'd0;
   logic        mode = 1'b0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b1;
   logic [2:0]  state;
   logic        ir_write, pc_write, mem_read, mem_write, addr_src, alu_src_b;
   logic [1:0]  pc_src, alu_op;
   logic        reg_write, wb_src, instr_done, illegal, mem_timeout;
   logic [15:0] instr_count;

   multicycle_control_unit #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mode(mode), .zero(zero),
      .mem_ready(mem_ready), .state(state), .ir_write(ir_write), .pc_write(pc_write),
      .pc_src(pc_src), .mem_read(mem_read), .mem_write(mem_write), .addr_src(addr_src),
      .alu_src_b(alu_src_b), .alu_op(alu_op), .reg_write(reg_write), .wb_src(wb_src),
      .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout),
      .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   // {state, ir_write, pc_write, pc_src, mem_read, mem_write, addr_src, alu_src_b,
   //  alu_op, reg_write, wb_src, instr_done, illegal, mem_timeout}
   logic [17:0] obs;
   assign obs = {state, ir_write, pc_write, pc_src, mem_read, mem_write, addr_src, alu_src_b,
                 alu_op, reg_write, wb_src, instr_done, illegal, mem_timeout};

   typedef struct {
      logic        rst;
      logic [3:0]  op;
      logic        md;
      logic        zr;
      logic        rdy;
      logic [17:0] exp;
      logic [15:0] cnt;
   } cyc_t;

   cyc_t  q[$];
   int    model_cnt = 0;
   int    n_checks = 0;
   int    n_fail = 0;
   string tname = "";

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s/%s: got %h expected %h (t=%0t)", tname, tag, got, want, $time);
      end
   endtask

   function automatic logic [17:0] ev(input logic [2:0] s, input logic irw, input logic pcw,
                                      input logic [1:0] pcs, input logic mr, input logic mw,
                                      input logic as, input logic asb, input logic [1:0] aop,
                                      input logic rw, input logic wbs, input logic dn,
                                      input logic il, input logic to);
      return {s, irw, pcw, pcs, mr, mw, as, asb, aop, rw, wbs, dn, il, to};
   endfunction

   task automatic push(input logic rst, input logic [3:0] op, input logic md, input logic zr,
                       input logic rdy, input logic [17:0] exp);
      cyc_t c;
      c.rst = rst; c.op = op; c.md = md; c.zr = zr; c.rdy = rdy; c.exp = exp;
      c.cnt = model_cnt[15:0];
      q.push_back(c);
      if (exp[2]) model_cnt++;
      if (rst) model_cnt = 0;
   endtask

   // Expected cycle-by-cycle behaviour of one instruction starting in FETCH.
   // fwait/mwait: mem_ready-low cycles in FETCH/MEM; cut stops mid-MEM (for a reset).
   task automatic gen(input logic [3:0] op, input logic md, input logic zr,
                      input int fwait, input int mwait, input bit cut);
      int c;
      logic [3:0] jop;
      logic       jmd;
      logic       lw, sw, tk;
      jop = ~op;
      jmd = ~md;
      lw  = (op == 4'd3);
      sw  = (op == 4'd4);
      c = 0;
      for (int i = 0; i < fwait; i++) begin
         if (c == TO - 1) begin
            push(0, op, md, zr, 0, ev(1,0,0,0,1,0,0,0,0,0,0,0,0,1));
            c = 0;
         end else begin
            push(0, op, md, zr, 0, ev(1,0,0,0,1,0,0,0,0,0,0,0,0,0));
            c++;
         end
      end
      push(0, op, md, zr, 1, ev(1,1,1,0,1,0,0,0,0,0,0,0,0,0));
      if (op == 4'd6) begin
         push(0, op, md, zr, 1, ev(2,0,1,2,0,0,0,0,0,0,0,1,0,0));
         return;
      end
      if (op > 4'd6) begin
         push(0, op, md, zr, 1, ev(2,0,0,0,0,0,0,0,0,0,0,0,1,0));
         return;
      end
      push(0, op, md, zr, 1, ev(2,0,0,0,0,0,0,0,0,0,0,0,0,0));
      // From EXEC onwards the IR fields are scrambled; the DUT must use its latched copy.
      if (op <= 4'd2) begin
         push(0, jop, jmd, zr, 1, ev(3,0,0,0,0,0,0,md,op[1:0],0,0,0,0,0));
         push(0, jop, jmd, zr, 1, ev(5,0,0,0,0,0,0,0,0,1,0,1,0,0));
      end else if (lw || sw) begin
         push(0, jop, jmd, zr, 1, ev(3,0,0,0,0,0,0,1,0,0,0,0,0,0));
         c = 0;
         for (int i = 0; i < mwait; i++) begin
            if (c == TO - 1) begin
               push(0, jop, jmd, zr, 0, ev(4,0,0,0,lw,sw,1,0,0,0,0,0,0,1));
               return;
            end
            push(0, jop, jmd, zr, 0, ev(4,0,0,0,lw,sw,1,0,0,0,0,0,0,0));
            c++;
         end
         if (cut) return;
         push(0, jop, jmd, zr, 1, ev(4,0,0,0,lw,sw,1,0,0,0,0,sw,0,0));
         if (lw) push(0, jop, jmd, zr, 1, ev(5,0,0,0,0,0,0,0,0,1,1,1,0,0));
      end else begin
         tk = zr ^ md;
         push(0, jop, jmd, zr, 1, ev(3,0,tk,{1'b0,tk},0,0,0,0,1,0,0,1,0,0));
      end
   endtask

   task automatic do_reset(input int cycles);
      for (int i = 0; i < cycles; i++) push(1, 4'd0, 0, 0, 1, 18'd0);
      push(0, 4'd0, 0, 0, 1, ev(0,0,0,0,0,0,0,0,0,0,0,0,0,0));
   endtask

   task automatic drain(input string name);
      cyc_t c;
      tname = name;
      while (q.size() > 0) begin
         c = q.pop_front();
         @(posedge clk);
         #1;
         reset     = c.rst;
         opcode    = c.op;
         mode      = c.md;
         zero      = c.zr;
         mem_ready = c.rdy;
         @(negedge clk);
         chk("outs", {14'd0, obs}, {14'd0, c.exp});
         chk("count", {16'd0, instr_count}, {16'd0, c.cnt});
      end
   endtask

   initial begin
      do_reset(2);                       drain("reset");
      gen(4'd0, 1, 0, 0, 0, 0);          drain("add_imm");
      gen(4'd1, 0, 0, 2, 0, 0);          drain("sub_reg_fwait");
      gen(4'd2, 1, 1, 0, 0, 0);          drain("and_imm");
      gen(4'd3, 0, 0, 0, 3, 0);          drain("lw_wait3");
      gen(4'd4, 1, 0, 1, 0, 0);          drain("sw");
      gen(4'd4, 0, 0, 0, 5, 0);          drain("sw_wait5");
      gen(4'd5, 0, 1, 0, 0, 0);          drain("beq_taken");
      gen(4'd5, 1, 1, 0, 0, 0);          drain("bne_not_taken");
      gen(4'd5, 0, 0, 0, 0, 0);          drain("beq_not_taken");
      gen(4'd5, 1, 0, 0, 0, 0);          drain("bne_taken");
      gen(4'd9, 0, 0, 0, 0, 0);          drain("illegal9");
      gen(4'd15, 1, 0, 0, 0, 0);         drain("illegal15");
      gen(4'd6, 0, 0, 0, 0, 0);          drain("jmp");
      gen(4'd0, 0, 0, TO, 0, 0);         drain("fetch_timeout");
      gen(4'd1, 1, 0, TO - 1, 0, 0);     drain("fetch_ready_at_limit");
      gen(4'd3, 1, 0, 0, TO, 0);         drain("lw_mem_timeout");
      gen(4'd3, 0, 0, 0, TO - 1, 0);     drain("lw_ready_at_limit");
      gen(4'd2, 0, 0, 2 * TO + 3, 0, 0); drain("double_fetch_timeout");
      gen(4'd3, 0, 0, 0, 2, 1);
      do_reset(1);                       drain("reset_mid_mem");
      gen(4'd0, 0, 0, 0, 0, 0);          drain("add_after_reset");
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
